ocra1_rx: RTL and testbench

// - Synthesizable receiver for the OCRA1 four-channel DAC SPI bus driven by ocra1_iface.
// - Oversamples sclk/syncn/ldacn/sdo* in the system clock domain and rebuilds each channel's 24-bit word.
// - Keeps per-channel DAC input, output and control registers, and presents the resulting 18-bit outputs.
// - Used for on-chip loopback self-test and for readback of the commanded gradient values.

---
 rtl/ocra1_pkg.sv | 27 ++
 rtl/ocra1_rx_chan.sv | 80 ++++++++
 rtl/ocra1_rx.sv | 196 +++++++++++++++++++
 tb/tb_ocra1_rx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ocra1_pkg.sv
// rtl/ocra1_pkg.sv - shared constants and FSM state type for the OCRA1 DAC bus receiver
// Contents:
//   ADDR_DAC / ADDR_CTRL   DAC register address codes carried in word[23:20]
//   CTRL_RESET             control register reset value (output grounded, DAC tristated)
//   OPGND / DACTRI         control bits that force the output code to zero
//   WORD_BITS_DEF / DATA_BITS_DEF   default frame and code widths
//   rx_state_e             receiver FSM states
package ocra1_pkg;

   localparam logic [3:0]  ADDR_DAC   = 4'h1;
   localparam logic [3:0]  ADDR_CTRL  = 4'h2;

   localparam logic [19:0] CTRL_RESET = 20'h0000C;
   localparam int          OPGND      = 2;
   localparam int          DACTRI     = 3;

   localparam int          WORD_BITS_DEF = 24;
   localparam int          DATA_BITS_DEF = 18;

   typedef enum logic [1:0] {
      ST_WAIT_IDLE = 2'd0,
      ST_IDLE      = 2'd1,
      ST_SHIFT     = 2'd2,
      ST_COMMIT    = 2'd3
   } rx_state_e;

endpackage

// File: rtl/ocra1_rx_chan.sv
// rtl/ocra1_rx_chan.sv - one DAC channel: shift register, input/output/control registers, output gating
// Ports:
//   clk, rst_n     system clock, synchronous active-low reset
//   shift_clr_i    clear the shift register (start of frame)
//   shift_en_i     shift sdo_i in at the LSB (synchronized sclk falling edge)
//   sdo_i          synchronized serial data for this channel
//   commit_i       good frame: decode the word and update input or control register
//   ldac_i         copy input register to output register
//   word_o         current shift register contents
//   vout_o         registered output code, forced to zero while OPGND or DACTRI is set
module ocra1_rx_chan
   import ocra1_pkg::*;
#(
   parameter int WORD_BITS = WORD_BITS_DEF,
   parameter int DATA_BITS = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 shift_clr_i,
   input  logic                 shift_en_i,
   input  logic                 sdo_i,
   input  logic                 commit_i,
   input  logic                 ldac_i,
   output logic [WORD_BITS-1:0] word_o,
   output logic [DATA_BITS-1:0] vout_o
);

   localparam int CTRL_BITS = WORD_BITS - 4;

   logic [WORD_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] in_q, in_d;
   logic [DATA_BITS-1:0] out_q, out_d;
   logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;
   logic [DATA_BITS-1:0] vout_q, vout_d;
   logic [3:0]           addr;
   logic                 dac_wr;
   logic                 ctrl_wr;

   always_comb begin
      shift_d = shift_q;
      if (shift_clr_i) begin
         shift_d = '0;
      end else if (shift_en_i) begin
         shift_d = {shift_q[WORD_BITS-2:0], sdo_i};
      end

      addr    = shift_q[WORD_BITS-1 -: 4];
      dac_wr  = commit_i && (addr == ADDR_DAC);
      ctrl_wr = commit_i && (addr == ADDR_CTRL);

      in_d   = dac_wr  ? shift_q[DATA_BITS+1:2] : in_q;
      ctrl_d = ctrl_wr ? shift_q[CTRL_BITS-1:0] : ctrl_q;

      // in_d rather than in_q: an LDAC landing in the commit cycle moves the
      // freshly written code straight through to the output register.
      out_d  = ldac_i ? in_d : out_q;

      vout_d = (ctrl_q[OPGND] | ctrl_q[DACTRI]) ? '0 : out_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift_q <= '0;
         in_q    <= '0;
         out_q   <= '0;
         ctrl_q  <= CTRL_BITS'(CTRL_RESET);
         vout_q  <= '0;
      end else begin
         shift_q <= shift_d;
         in_q    <= in_d;
         out_q   <= out_d;
         ctrl_q  <= ctrl_d;
         vout_q  <= vout_d;
      end
   end

   assign word_o = shift_q;
   assign vout_o = vout_q;

endmodule

// File: rtl/ocra1_rx.sv
// rtl/ocra1_rx.sv - OCRA1 four-channel DAC SPI bus receiver with per-channel register model
// Ports:
//   clk, rst_n                     system clock, synchronous active-low reset
//   oc1_clk_i                      SPI sclk, data sampled on its falling edge
//   oc1_syncn_i, oc1_ldacn_i       frame select and load-DAC strobes, active-low
//   oc1_sdo{x,y,z,z2}_i            serial data per channel, MSB first
//   vout{x,y,z,z2}_o               DAC output codes
//   rx_words_o                     last good frame {z2,z,y,x}
//   rx_valid_o                     one-cycle pulse when rx_words_o is loaded
//   update_o                       one-cycle pulse per LDAC transfer
//   frame_err_o                    sticky bad-length frame flag
//   frame_cnt_o                    good-frame counter, wraps
module ocra1_rx
   import ocra1_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int WORD_BITS   = WORD_BITS_DEF,
   parameter int DATA_BITS   = DATA_BITS_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   oc1_clk_i,
   input  logic                   oc1_syncn_i,
   input  logic                   oc1_ldacn_i,
   input  logic                   oc1_sdox_i,
   input  logic                   oc1_sdoy_i,
   input  logic                   oc1_sdoz_i,
   input  logic                   oc1_sdoz2_i,
   output logic [DATA_BITS-1:0]   voutx_o,
   output logic [DATA_BITS-1:0]   vouty_o,
   output logic [DATA_BITS-1:0]   voutz_o,
   output logic [DATA_BITS-1:0]   voutz2_o,
   output logic [4*WORD_BITS-1:0] rx_words_o,
   output logic                   rx_valid_o,
   output logic                   update_o,
   output logic                   frame_err_o,
   output logic [15:0]            frame_cnt_o
);

   localparam int NIN      = 7;
   localparam int BITCNT_W = $clog2(WORD_BITS + 2);
   localparam logic [BITCNT_W-1:0] BITCNT_FULL = BITCNT_W'(WORD_BITS);
   localparam logic [BITCNT_W-1:0] BITCNT_SAT  = BITCNT_W'(WORD_BITS + 1);

   // Bit order {sdoz2, sdoz, sdoy, sdox, ldacn, syncn, sclk}. ldacn resets to
   // its idle high so no false LDAC follows reset; syncn resets low so that
   // WAIT_IDLE only leaves once a real high level has crossed the synchronizer.
   localparam logic [NIN-1:0] SYNC_RST = 7'b000_0100;

   logic [NIN-1:0]                  pins;
   logic [NIN-1:0]                  synced;
   logic [SYNC_STAGES-1:0][NIN-1:0] sync_q, sync_d;
   logic [2:0]                      prev_q, prev_d;

   logic sclk_fall, syncn_fall, syncn_rise, ldac_fall;

   rx_state_e             state_q, state_d;
   logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
   logic                  frame_err_q, frame_err_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  update_q, update_d;
   logic [4*WORD_BITS-1:0] rx_words_q, rx_words_d;

   logic                  shift_clr;
   logic                  shift_en;
   logic                  commit;
   logic [WORD_BITS-1:0]  word_x, word_y, word_z, word_z2;

   assign pins = {oc1_sdoz2_i, oc1_sdoz_i, oc1_sdoy_i, oc1_sdox_i,
                  oc1_ldacn_i, oc1_syncn_i, oc1_clk_i};

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = pins;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];
   assign prev_d = synced[2:0];

   assign sclk_fall  =  prev_q[0] & ~synced[0];
   assign syncn_fall =  prev_q[1] & ~synced[1];
   assign syncn_rise = ~prev_q[1] &  synced[1];
   assign ldac_fall  =  prev_q[2] & ~synced[2];

   always_comb begin
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      frame_err_d = frame_err_q;
      frame_cnt_d = frame_cnt_q;
      rx_valid_d  = 1'b0;
      shift_clr   = 1'b0;
      shift_en    = 1'b0;
      commit      = 1'b0;

      case (state_q)
         ST_WAIT_IDLE: begin
            if (synced[1]) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (syncn_fall) begin
               state_d   = ST_SHIFT;
               bitcnt_d  = '0;
               shift_clr = 1'b1;
            end
         end
         ST_SHIFT: begin
            // End of frame wins over a coincident sclk edge.
            if (syncn_rise) begin
               state_d = ST_COMMIT;
            end else if (sclk_fall) begin
               shift_en = 1'b1;
               if (bitcnt_q != BITCNT_SAT) begin
                  bitcnt_d = bitcnt_q + BITCNT_W'(1);
               end
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
            if (bitcnt_q == BITCNT_FULL) begin
               commit      = 1'b1;
               rx_valid_d  = 1'b1;
               frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_WAIT_IDLE;
         end
      endcase

      rx_words_d = commit ? {word_z2, word_z, word_y, word_x} : rx_words_q;
      update_d   = ldac_fall;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q      <= {SYNC_STAGES{SYNC_RST}};
         prev_q      <= SYNC_RST[2:0];
         state_q     <= ST_WAIT_IDLE;
         bitcnt_q    <= '0;
         frame_err_q <= 1'b0;
         frame_cnt_q <= '0;
         rx_valid_q  <= 1'b0;
         update_q    <= 1'b0;
         rx_words_q  <= '0;
      end else begin
         sync_q      <= sync_d;
         prev_q      <= prev_d;
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         frame_err_q <= frame_err_d;
         frame_cnt_q <= frame_cnt_d;
         rx_valid_q  <= rx_valid_d;
         update_q    <= update_d;
         rx_words_q  <= rx_words_d;
      end
   end

   ocra1_rx_chan #(.WORD_BITS(WORD_BITS), .DATA_BITS(DATA_BITS)) u_chan_x (
      .clk(clk), .rst_n(rst_n), .shift_clr_i(shift_clr), .shift_en_i(shift_en),
      .sdo_i(synced[3]), .commit_i(commit), .ldac_i(ldac_fall),
      .word_o(word_x), .vout_o(voutx_o)
   );

   ocra1_rx_chan #(.WORD_BITS(WORD_BITS), .DATA_BITS(DATA_BITS)) u_chan_y (
      .clk(clk), .rst_n(rst_n), .shift_clr_i(shift_clr), .shift_en_i(shift_en),
      .sdo_i(synced[4]), .commit_i(commit), .ldac_i(ldac_fall),
      .word_o(word_y), .vout_o(vouty_o)
   );

   ocra1_rx_chan #(.WORD_BITS(WORD_BITS), .DATA_BITS(DATA_BITS)) u_chan_z (
      .clk(clk), .rst_n(rst_n), .shift_clr_i(shift_clr), .shift_en_i(shift_en),
      .sdo_i(synced[5]), .commit_i(commit), .ldac_i(ldac_fall),
      .word_o(word_z), .vout_o(voutz_o)
   );

   ocra1_rx_chan #(.WORD_BITS(WORD_BITS), .DATA_BITS(DATA_BITS)) u_chan_z2 (
      .clk(clk), .rst_n(rst_n), .shift_clr_i(shift_clr), .shift_en_i(shift_en),
      .sdo_i(synced[6]), .commit_i(commit), .ldac_i(ldac_fall),
      .word_o(word_z2), .vout_o(voutz2_o)
   );

   assign rx_words_o  = rx_words_q;
   assign rx_valid_o  = rx_valid_q;
   assign update_o    = update_q;
   assign frame_err_o = frame_err_q;
   assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_ocra1_rx.sv
// tb/tb_ocra1_rx.sv - bit-banged OCRA1 bus stimulus against a register-level reference model
module tb_ocra1_rx;

   logic        clk = 1'b0;
   logic        rst_n, sclk, syncn, ldacn, sx, sy, sz, sz2;
   logic [17:0] vx, vy, vz, vz2;
   logic [95:0] rxw;
   logic        rxv, upd, ferr;
   logic [15:0] fcnt;

   int n_checks = 0;
   int n_err    = 0;
   int upd_seen = 0;
   int val_seen = 0;
   int hp       = 2;

   // reference model: DAC register file as the bus protocol describes it
   logic [17:0] m_in   [4];
   logic [17:0] m_out  [4];
   logic [19:0] m_ctrl [4];
   logic [95:0] m_words;
   logic [15:0] m_fcnt;
   logic        m_ferr;
   int          m_upd = 0;
   int          m_val = 0;

   always #5 clk = ~clk;

   ocra1_rx dut (
      .clk(clk), .rst_n(rst_n),
      .oc1_clk_i(sclk), .oc1_syncn_i(syncn), .oc1_ldacn_i(ldacn),
      .oc1_sdox_i(sx), .oc1_sdoy_i(sy), .oc1_sdoz_i(sz), .oc1_sdoz2_i(sz2),
      .voutx_o(vx), .vouty_o(vy), .voutz_o(vz), .voutz2_o(vz2),
      .rx_words_o(rxw), .rx_valid_o(rxv), .update_o(upd),
      .frame_err_o(ferr), .frame_cnt_o(fcnt)
   );

   always @(negedge clk) begin
      if (upd === 1'b1) upd_seen++;
      if (rxv === 1'b1) val_seen++;
   end

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [23:0] mkv(input int v);
      logic [17:0] t;
      t = v[17:0];
      return {4'h1, t, 2'b00};
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         m_in[c]   = '0;
         m_out[c]  = '0;
         m_ctrl[c] = 20'h0000C;
      end
      m_words = '0;
      m_fcnt  = '0;
      m_ferr  = 1'b0;
   endtask

   task automatic model_frame(input logic [95:0] w, input int nbits);
      logic [23:0] cw;
      if (nbits != 24) begin
         m_ferr = 1'b1;
         return;
      end
      m_words = w;
      m_fcnt  = m_fcnt + 16'd1;
      m_val++;
      for (int c = 0; c < 4; c++) begin
         cw = w[c*24 +: 24];
         if (cw[23:20] == 4'h1) m_in[c] = cw[19:2];
         else if (cw[23:20] == 4'h2) m_ctrl[c] = cw[19:0];
      end
   endtask

   task automatic model_ldac();
      for (int c = 0; c < 4; c++) m_out[c] = m_in[c];
      m_upd++;
   endtask

   task automatic check_all(input string tag);
      logic [17:0] got;
      logic [17:0] exp;
      for (int c = 0; c < 4; c++) begin
         case (c)
            0: got = vx;
            1: got = vy;
            2: got = vz;
            default: got = vz2;
         endcase
         exp = (m_ctrl[c][2] | m_ctrl[c][3]) ? 18'h0 : m_out[c];
         check($sformatf("%s vout%0d", tag, c), got, exp);
      end
      check({tag, " rx_words"}, rxw, m_words);
      check({tag, " frame_cnt"}, fcnt, m_fcnt);
      check({tag, " frame_err"}, ferr, m_ferr);
      check({tag, " update_cnt"}, upd_seen, m_upd);
      check({tag, " valid_cnt"}, val_seen, m_val);
   endtask

   task automatic do_reset();
      sclk = 0; syncn = 1; ldacn = 1; sx = 0; sy = 0; sz = 0; sz2 = 0;
      rst_n = 0;
      tick(4);
      rst_n = 1;
      model_reset();
      tick(4);
   endtask

   task automatic ldac_pulse();
      ldacn = 0;
      tick(3);
      ldacn = 1;
      tick(6);
      model_ldac();
   endtask

   // rst_bit >= 0 pulses rst_n just before that bit; ldac_commit drops ldacn
   // one clock after syncn rises so it is seen in the commit cycle.
   task automatic send_frame(input logic [95:0] w, input int nbits, input int rst_bit,
                             input bit ldac_commit);
      bit was_reset = 0;
      syncn = 0;
      tick(hp + 1);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_bit) begin
            rst_n = 0;
            tick(3);
            rst_n = 1;
            model_reset();
            was_reset = 1;
         end
         sx  = w[0*24 + 23 - i];
         sy  = w[1*24 + 23 - i];
         sz  = w[2*24 + 23 - i];
         sz2 = w[3*24 + 23 - i];
         sclk = 1;
         tick(hp);
         sclk = 0;
         tick(hp);
      end
      syncn = 1;
      if (ldac_commit) begin
         tick(1);
         ldacn = 0;
         tick(3);
         ldacn = 1;
      end
      tick(hp + 8);
      sx = 0; sy = 0; sz = 0; sz2 = 0;
      if (!was_reset) model_frame(w, nbits);
      if (ldac_commit) model_ldac();
   endtask

   task automatic send_v(input int a, input int b, input int c, input int d, input bit ld);
      send_frame({mkv(d), mkv(c), mkv(b), mkv(a)}, 24, -1, 0);
      if (ld) ldac_pulse();
   endtask

   task automatic run_pass(input int div);
      logic [95:0] w;
      logic [31:0] t;
      int          nb;
      hp = div + 1;
      do_reset();
      check_all("reset");

      send_v(5, 6, 7, 8, 1);
      check_all("noinit");
      send_frame({4{24'h200002}}, 24, -1, 0);
      check_all("init");

      send_v(1, 2, 3, 4, 1);
      check_all("v1234");
      send_v(-1, -2, -3, -4, 1);
      check_all("vneg");

      send_frame({mkv(7), mkv(7), mkv(7), mkv(7)}, 23, -1, 0);
      check_all("short");
      send_v(11, 12, 13, 14, 1);
      check_all("after_short");

      send_frame({mkv(9), mkv(9), mkv(9), mkv(9)}, 24, -1, 1);
      check_all("ldac_commit");

      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 4; c++) begin
            t = $urandom;
            case ($urandom_range(0, 3))
               0: w[c*24 +: 24] = {4'h1, t[17:0], 2'($urandom)};
               1: begin
                  if ($urandom_range(0, 3) != 0) t[3:2] = 2'b00;
                  w[c*24 +: 24] = {4'h2, t[19:0]};
               end
               default: w[c*24 +: 24] = t[23:0];
            endcase
         end
         nb = ($urandom_range(0, 5) == 0) ? 25 : 24;
         send_frame(w, nb, -1, 0);
         if ($urandom_range(0, 1) == 1) ldac_pulse();
         check_all("rand");
      end

      send_frame({mkv(3), mkv(3), mkv(3), mkv(3)}, 24, 10, 0);
      check_all("midrst");
      send_frame({4{24'h200002}}, 24, -1, 0);
      send_v(1, 2, 3, 4, 1);
      check_all("post_rst");
      check("post_rst fcnt_two", fcnt, 2);
   endtask

   initial begin
      rst_n = 0; sclk = 0; syncn = 1; ldacn = 1; sx = 0; sy = 0; sz = 0; sz2 = 0;
      model_reset();
      run_pass(32);
      run_pass(1);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
      $fatal(1, "timeout");
   end

endmodule
